// File: rtl/md_pad_emu.sv
// -----------------------------------------------------------------------------
// md_pad_emu
//   Device-side emulator of a Megadrive 3/6-button pad. It answers the
//   host's SELECT line by driving the six DB9 data pins from a MiSTer
//   joystick bitmap. This is the pad end of the MD protocol, so it can also
//   serve as a loopback source for a DB9 MD reader.
//
// Parameters
//   TIMEOUT_CYCLES  clk cycles with no SELECT edge before the 6-button phase
//                   counter falls back to 0 (fits the 17-bit timer)
//   SYNC_STAGES     synchroniser depth on sel_in (minimum 2)
//
// Ports
//   clk         in   core clock, all state on its rising edge
//   reset       in   asynchronous, active-high reset
//   sel_in      in   SELECT from the host, asynchronous to clk
//   joystick    in   [11:0] active-high buttons MSZYXCBAUDLR
//   six_btn_en  in   1 = 6-button protocol, 0 = plain 3-button pad
//   pad_out     out  [5:0] active-low DB9 data pins, registered
//   phase       out  [2:0] current rising-edge count, 0..4 (debug)
// -----------------------------------------------------------------------------
module md_pad_emu #(
    parameter int TIMEOUT_CYCLES = 75000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_in,
    input  logic [11:0] joystick,
    input  logic        six_btn_en,
    output logic [5:0]  pad_out,
    output logic [2:0]  phase
);

    localparam logic [2:0] PH_0 = 3'd0;
    localparam logic [2:0] PH_1 = 3'd1;
    localparam logic [2:0] PH_2 = 3'd2;
    localparam logic [2:0] PH_3 = 3'd3;
    localparam logic [2:0] PH_4 = 3'd4;

    localparam logic [16:0] TIMEOUT_MAX = 17'(TIMEOUT_CYCLES);
    localparam logic [16:0] TIMEOUT_PRE = 17'(TIMEOUT_CYCLES - 1);

    // Named button views of the joystick bitmap.
    logic btn_m, btn_s, btn_z, btn_y, btn_x, btn_c;
    logic btn_b, btn_a, btn_u, btn_d, btn_l, btn_r;

    assign {btn_m, btn_s, btn_z, btn_y, btn_x, btn_c,
            btn_b, btn_a, btn_u, btn_d, btn_l, btn_r} = joystick;

    // -------------------------------------------------------------------------
    // SELECT synchroniser and edge detect
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sel_d_q;
    logic                   sel_s;
    logic                   rise;
    logic                   fall;

    // NOTE: sequential state is assigned with <= only, so every flop samples
    // pre-edge values and the async reset branch comes first in each block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '1;
            sel_d_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sel_in};
            sel_d_q <= sel_s;
        end
    end

    assign sel_s = sync_q[SYNC_STAGES-1];
    assign rise  =  sel_s & ~sel_d_q;
    assign fall  = ~sel_s &  sel_d_q;

    // -------------------------------------------------------------------------
    // Phase counter and inactivity timer
    // -------------------------------------------------------------------------
    logic [2:0]  cnt_q,   cnt_d;
    logic [16:0] timer_q, timer_d;
    logic        timeout;

    // The timer arrives at TIMEOUT_CYCLES on this edge (or already sits
    // there), so the counter drops to 0 on the same edge. A coincident rise
    // still counts as the first rise of a new sequence.
    assign timeout = (timer_q >= TIMEOUT_PRE);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (!six_btn_en) begin
            cnt_d   = PH_0;
            timer_d = '0;
        end else begin
            if (rise || fall)
                timer_d = '0;
            else if (timer_q != TIMEOUT_MAX)
                timer_d = timer_q + 17'd1;

            if (rise)
                cnt_d = timeout ? PH_1 : ((cnt_q == PH_4) ? PH_4 : cnt_q + 3'd1);
            else if (timeout)
                cnt_d = PH_0;
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping, from sel_s and the counter value being loaded this edge
    // -------------------------------------------------------------------------
    logic [5:0] pad_q, pad_d;

    always_comb begin
        pad_d = 6'h3F;
        if (sel_s) begin
            if (cnt_d == PH_3)
                pad_d = ~{btn_c, btn_b, btn_z, btn_y, btn_x, btn_m};
            else
                pad_d = ~{btn_c, btn_b, btn_u, btn_d, btn_l, btn_r};
        end else begin
            case (cnt_d)
                PH_2:    pad_d = {~btn_s, ~btn_a, 4'b0000};          // 6-button ID
                PH_3:    pad_d = {~btn_s, ~btn_a, 4'b1111};
                default: pad_d = {~btn_s, ~btn_a, ~btn_u, ~btn_d, 2'b00}; // MD ID
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= PH_0;
            timer_q <= '0;
            pad_q   <= 6'h3F;
        end else begin
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            pad_q   <= pad_d;
        end
    end

    assign pad_out = pad_q;
    assign phase   = cnt_q;

endmodule

// File: tb/tb_md_pad_emu.sv
// -----------------------------------------------------------------------------
// tb_md_pad_emu
//   Directed bench for md_pad_emu: a table of {inputs, expected pins, expected
//   phase} records for the steady protocol, then hand-written sequences for
//   timeout, reset abort, rise-at-timeout and six_btn_en dropping.
//   A short TIMEOUT_CYCLES keeps the timeout sequences quick.
// -----------------------------------------------------------------------------
module tb_md_pad_emu;

    localparam int TB_TIMEOUT = 200;

    logic        clk;
    logic        reset;
    logic        sel_in;
    logic [11:0] joystick;
    logic        six_btn_en;
    logic [5:0]  pad_out;
    logic [2:0]  phase;

    md_pad_emu #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel_in     (sel_in),
        .joystick   (joystick),
        .six_btn_en (six_btn_en),
        .pad_out    (pad_out),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
    endtask

    // Drive inputs on a falling edge, then wait out the sel_in -> pad_out
    // latency (2 sync flops + output register) and sample just after the edge.
    task automatic apply(input logic s, input logic six, input logic [11:0] j);
        @(negedge clk);
        sel_in     = s;
        six_btn_en = six;
        joystick   = j;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [5:0] exp_pad, input logic [2:0] exp_ph);
        check({name, " pad"},   {2'b00, pad_out}, {2'b00, exp_pad});
        check({name, " phase"}, {5'b0, phase},    {5'b0, exp_ph});
    endtask

    typedef struct {
        logic        sel;
        logic        six;
        logic [11:0] joy;
        logic [5:0]  exp_pad;
        logic [2:0]  exp_phase;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic s, input logic six, input logic [11:0] j,
                           input logic [5:0] p, input logic [2:0] ph);
        vec_t v;
        v.sel = s; v.six = six; v.joy = j; v.exp_pad = p; v.exp_phase = ph;
        vecs.push_back(v);
    endtask

    // Bounds the whole run in case the clock or a sequence stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 3-button mode: A pressed, then several pulses; phase never moves
        // and [3:0] never shows the 6-button 0000 ID.
        add_vec(1'b0, 1'b0, 12'h010, 6'h2C, 3'd0);
        add_vec(1'b1, 1'b0, 12'h010, 6'h3F, 3'd0);
        add_vec(1'b0, 1'b0, 12'h010, 6'h2C, 3'd0);
        add_vec(1'b1, 1'b0, 12'h010, 6'h3F, 3'd0);
        add_vec(1'b0, 1'b0, 12'h010, 6'h2C, 3'd0);
        add_vec(1'b1, 1'b0, 12'h010, 6'h3F, 3'd0);
        add_vec(1'b0, 1'b0, 12'h010, 6'h2C, 3'd0);
        add_vec(1'b1, 1'b0, 12'h010, 6'h3F, 3'd0);
        // 3-button mode, other button patterns on both SELECT levels.
        add_vec(1'b0, 1'b0, 12'hFFF, 6'h00, 3'd0);
        add_vec(1'b1, 1'b0, 12'hFFF, 6'h00, 3'd0);
        add_vec(1'b1, 1'b0, 12'h0C5, 6'h1A, 3'd0);  // X,C,D,R
        add_vec(1'b0, 1'b0, 12'h0C5, 6'h38, 3'd0);
        add_vec(1'b0, 1'b0, 12'h418, 6'h04, 3'd0);  // S,A,U
        add_vec(1'b1, 1'b0, 12'h418, 6'h37, 3'd0);
        // Enable 6-button mode while idle high, then Z,X pressed: L,H x4.
        add_vec(1'b1, 1'b1, 12'h280, 6'h3F, 3'd0);
        add_vec(1'b0, 1'b1, 12'h280, 6'h3C, 3'd0);
        add_vec(1'b1, 1'b1, 12'h280, 6'h3F, 3'd1);
        add_vec(1'b0, 1'b1, 12'h280, 6'h3C, 3'd1);
        add_vec(1'b1, 1'b1, 12'h280, 6'h3F, 3'd2);
        add_vec(1'b0, 1'b1, 12'h280, 6'h30, 3'd2);
        add_vec(1'b1, 1'b1, 12'h280, 6'h35, 3'd3);
        add_vec(1'b0, 1'b1, 12'h280, 6'h3F, 3'd3);
        add_vec(1'b1, 1'b1, 12'h280, 6'h3F, 3'd4);

        // ---------------- reset state ----------------
        reset      = 1'b0;
        sel_in     = 1'b1;
        joystick   = 12'h000;
        six_btn_en = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 6'h3F, 3'd0);
        @(negedge clk);
        reset = 1'b0;

        // sel low reaches the pins on the third clk, not the second.
        @(negedge clk);
        sel_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("latency 2clk pad", {2'b00, pad_out}, 8'h3F);
        @(posedge clk);
        #1;
        check("latency 3clk pad", {2'b00, pad_out}, 8'h3C);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].sel, vecs[i].six, vecs[i].joy);
            check_out($sformatf("vec%0d", i), vecs[i].exp_pad, vecs[i].exp_phase);
        end

        // ---------------- timeout ----------------
        // The last vector's rise cleared the timer on the edge just sampled.
        repeat (TB_TIMEOUT - 1) @(posedge clk);
        #1;
        check("timeout-1 phase", {5'b0, phase}, 8'd4);
        @(posedge clk);
        #1;
        check("timeout phase", {5'b0, phase}, 8'd0);
        apply(1'b0, 1'b1, 12'h280);
        check_out("after timeout low", 6'h3C, 3'd0);

        // ---------------- reset mid-sequence ----------------
        apply(1'b1, 1'b1, 12'h900);                 // M,Y pressed
        check_out("rst seq h1", 6'h3F, 3'd1);
        apply(1'b0, 1'b1, 12'h900);
        apply(1'b1, 1'b1, 12'h900);
        apply(1'b0, 1'b1, 12'h900);
        check_out("rst seq l3", 6'h30, 3'd2);
        apply(1'b1, 1'b1, 12'h900);
        check_out("rst seq h3", 6'h3A, 3'd3);       // C,B,Z,Y,X,M
        #2 reset = 1'b1;
        #1;
        check_out("async reset", 6'h3F, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        apply(1'b0, 1'b1, 12'h900);
        check_out("post reset low", 6'h3C, 3'd0);
        apply(1'b1, 1'b1, 12'h900);
        check_out("post reset high", 6'h3F, 3'd1);

        // ---------------- rise exactly at timeout ----------------
        apply(1'b0, 1'b1, 12'h900);
        apply(1'b1, 1'b1, 12'h900);
        check_out("pre timeout h2", 6'h3F, 3'd2);
        // Fall is detected on the 3rd edge after this drive; the rise driven
        // after edge TB_TIMEOUT is detected exactly TB_TIMEOUT edges later.
        @(negedge clk);
        sel_in = 1'b0;
        repeat (TB_TIMEOUT) @(posedge clk);
        #1;
        check_out("before timeout rise", 6'h30, 3'd2);
        @(negedge clk);
        sel_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_out("rise at timeout", 6'h3F, 3'd1);

        // ---------------- six_btn_en dropping at phase 2, sel low ----------------
        apply(1'b0, 1'b1, 12'h900);
        apply(1'b1, 1'b1, 12'h900);
        apply(1'b0, 1'b1, 12'h008);                 // U pressed
        check_out("phase2 low", 6'h30, 3'd2);
        @(negedge clk);
        six_btn_en = 1'b0;
        @(posedge clk);
        #1;
        check_out("six off", 6'h34, 3'd0);

        // joystick reaches the pins one clk after it changes
        @(negedge clk);
        joystick = 12'h004;                         // D pressed
        #1;
        check("joy before edge pad", {2'b00, pad_out}, 8'h34);
        @(posedge clk);
        #1;
        check("joy after edge pad", {2'b00, pad_out}, 8'h38);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
